// File: rtl/game_pkg.sv
// Shared game-level definitions: FSM state encoding, lives type/width,
// lives ceiling, default clock rate and a saturating lives increment helper.
package game_pkg;

    localparam int LIVES_W   = 2;
    localparam int MAX_LIVES = 3;
    localparam int CLK_HZ    = 50_000_000;   // default system clock; 1 s of grace

    typedef logic [LIVES_W-1:0] lives_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        GRACE = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Add one life, holding at ceiling instead of wrapping to 0.
    function automatic lives_t lives_inc(input lives_t cur, input int ceiling);
        if (int'(cur) >= ceiling)
            return lives_t'(ceiling);
        return cur + lives_t'(1);
    endfunction

endpackage

// File: rtl/grace_timer.sv
// Loadable down-counter. Counts down by one per cycle until it reaches 0
// and then holds there.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (count <= 0)
//   clear          : force count to 0 (wins over load)
//   load, load_val : load a new start value
//   done           : count is 0
module grace_timer
    import game_pkg::*;
#(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/lives_tracker.sv
// Lives bookkeeping for the game. Consumes one-cycle gameplay pulses and
// keeps the registered lives count feeding the 7-segment decoder, plus the
// game-over flag, the post-hit grace window and a life-lost pulse.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin / restart a game (highest priority after reset)
//   bomb        : bomb sliced, ends the game from PLAY or GRACE
//   miss        : fruit dropped, costs one life (ignored during grace)
//   bonus       : bonus life, saturates at MAX_LIVES
//   lives       : current lives, binary 0..3
//   game_over   : high while in OVER
//   grace       : high while in GRACE
//   life_lost   : one-cycle pulse on every decrement
module lives_tracker
    import game_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = game_pkg::MAX_LIVES,
    parameter int GRACE_CYCLES = game_pkg::CLK_HZ,
    parameter int GRACE_W      = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               miss,
    input  logic               bomb,
    input  logic               bonus,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               grace,
    output logic               life_lost
);

    state_t state, state_next;
    lives_t lives_next;
    logic   lost_next, over_next, grace_next;
    logic   tmr_load, tmr_clear, tmr_done;

    grace_timer #(.W(GRACE_W)) u_grace_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (GRACE_W'(GRACE_CYCLES - 1)),
        .done     (tmr_done)
    );

    // State, lives and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lives     <= lives_t'(START_LIVES);
            game_over <= 1'b0;
            grace     <= 1'b0;
            life_lost <= 1'b0;
        end else begin
            state     <= state_next;
            lives     <= lives_next;
            game_over <= over_next;
            grace     <= grace_next;
            life_lost <= lost_next;
        end
    end

    // Next state and lives. Priority: start > bomb > miss > bonus.
    always_comb begin
        state_next = state;
        lives_next = lives;
        lost_next  = 1'b0;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        if (start) begin
            state_next = PLAY;
            lives_next = lives_t'(START_LIVES);
            tmr_clear  = 1'b1;
        end else begin
            unique case (state)
                IDLE: lives_next = lives_t'(START_LIVES);
                PLAY: begin
                    if (bomb) begin
                        lives_next = '0;
                        lost_next  = 1'b1;
                        state_next = OVER;
                    end else if (miss) begin
                        lost_next = 1'b1;
                        if (lives > lives_t'(1)) begin
                            lives_next = lives - lives_t'(1);
                            tmr_load   = 1'b1;
                            state_next = GRACE;
                        end else begin
                            lives_next = '0;
                            state_next = OVER;
                        end
                    end else if (bonus) begin
                        lives_next = lives_inc(lives, MAX_LIVES);
                    end
                end
                GRACE: begin
                    if (bomb) begin
                        lives_next = '0;
                        lost_next  = 1'b1;
                        tmr_clear  = 1'b1;
                        state_next = OVER;
                    end else begin
                        // miss is treated as absent here, so a coincident
                        // bonus still lands
                        if (bonus)
                            lives_next = lives_inc(lives, MAX_LIVES);
                        // timer loaded with GRACE_CYCLES-1, so reading 0 marks
                        // the last grace cycle
                        if (tmr_done)
                            state_next = PLAY;
                    end
                end
                OVER: lives_next = '0;
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered outputs follow the upcoming state
    always_comb begin
        over_next  = (state_next == OVER);
        grace_next = (state_next == GRACE);
    end

endmodule

// File: tb/tb_lives_tracker.sv
module tb_lives_tracker;

    localparam int START = 3;
    localparam int MAXL  = 3;
    localparam int G     = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, miss = 1'b0, bomb = 1'b0, bonus = 1'b0;
    logic [1:0] lives;
    logic       game_over, grace, life_lost;

    lives_tracker #(
        .START_LIVES(START), .MAX_LIVES(MAXL), .GRACE_CYCLES(G), .GRACE_W(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .miss(miss), .bomb(bomb),
        .bonus(bonus), .lives(lives), .game_over(game_over), .grace(grace),
        .life_lost(life_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lives;
        logic       over;
        logic       grace;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0, mismatched = 0, cyc = 0;

    // Reference model: game as a few plain counters
    int m_lives = START, m_grace_left = 0;
    bit m_started = 0, m_over = 0, m_lost = 0;

    task automatic model_step(input bit r, s, m, b, bo);
        m_lost = 0;
        if (r) begin
            m_lives = START; m_started = 0; m_over = 0; m_grace_left = 0;
        end else if (s) begin
            m_lives = START; m_started = 1; m_over = 0; m_grace_left = 0;
        end else if (m_started && !m_over) begin
            if (b) begin
                m_lives = 0; m_over = 1; m_grace_left = 0; m_lost = 1;
            end else if (m && m_grace_left == 0) begin
                m_lost = 1;
                if (m_lives > 1) begin m_lives--; m_grace_left = G; end
                else begin m_lives = 0; m_over = 1; end
            end else begin
                if (bo) m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
                if (m_grace_left > 0) m_grace_left--;
            end
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after the edge
    task automatic cycle(input bit r, s, m, b, bo);
        exp_t e;
        @(negedge clk);
        reset = r; start = s; miss = m; bomb = b; bonus = bo;
        model_step(r, s, m, b, bo);
        e.lives = 2'(m_lives);
        e.over  = m_over;
        e.grace = (m_grace_left > 0);
        e.lost  = m_lost;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    // Monitor: every output cycle pops one expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared += 4;
            if (lives !== e.lives) begin
                mismatched++;
                $display("FAIL lives cyc=%0d got=%0d want=%0d", cyc, lives, e.lives);
            end
            if (game_over !== e.over) begin
                mismatched++;
                $display("FAIL game_over cyc=%0d got=%0b want=%0b", cyc, game_over, e.over);
            end
            if (grace !== e.grace) begin
                mismatched++;
                $display("FAIL grace cyc=%0d got=%0b want=%0b", cyc, grace, e.grace);
            end
            if (life_lost !== e.lost) begin
                mismatched++;
                $display("FAIL life_lost cyc=%0d got=%0b want=%0b", cyc, life_lost, e.lost);
            end
        end
    end

    initial begin
        // reset, then start
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1);         // IDLE ignores events
        cycle(0, 1, 0, 0, 0);
        idle(2);
        // miss at 3, second miss inside grace, miss after grace
        cycle(0, 0, 1, 0, 0);
        idle(1);
        cycle(0, 0, 1, 0, 0);
        idle(3);
        cycle(0, 0, 1, 0, 0);         // lives 1
        idle(5);
        cycle(0, 0, 1, 0, 0);         // final miss -> OVER
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);         // restart
        // bonus at max, bonus during grace, miss+bonus same cycle
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 1);
        idle(5);
        cycle(0, 0, 1, 0, 1);
        // bomb during grace, then bomb+start
        cycle(0, 0, 0, 0, 1);         // back to 3 inside grace
        cycle(0, 0, 0, 1, 0);
        idle(1);
        cycle(0, 1, 0, 1, 0);
        idle(1);
        // reset mid-grace at lives 1
        cycle(0, 0, 1, 0, 0);
        idle(5);
        cycle(0, 0, 1, 0, 0);
        idle(1);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(1);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 5) == 0));
        // drain scoreboard with a bound
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
